banked_mem_responder: RTL and testbench

- Four-bank interleaved main-memory responder serving the direct-mapped cache controller's memory-side requests (`mem_rd`/`mem_wr` into `rd`/`wr`).
- Accepts one word request per cycle. It stalls a request whose target bank is still occupied, and returns read data a fixed number of cycles after acceptance.
- Exports per-bank busy flags so the initiator can sequence multi-word line transfers across banks.
- Sits between the cache block and the backing store. It replaces the behavioural memory model in synthesizable form.

---
 rtl/banked_mem_responder_if.sv | 35 +++
 rtl/banked_mem_responder.sv | 123 ++++++++++++
 tb/tb_banked_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/banked_mem_responder_if.sv
// -----------------------------------------------------------------------------
// banked_mem_responder_if
// Word-request bus between the cache controller (master) and the banked
// memory responder (slave).
//   addr     : byte address of the request (master -> slave)
//   data_in  : write data                  (master -> slave)
//   rd / wr  : read / write request strobes (master -> slave)
//   data_out : read data, zero outside its valid cycle (slave -> master)
//   stall    : request not accepted, hold it (slave -> master)
//   busy     : per-bank occupancy flags      (slave -> master)
//   err      : request is illegal, dropped   (slave -> master)
// -----------------------------------------------------------------------------
interface banked_mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic              wr;
   logic [DATA_W-1:0] data_out;
   logic              stall;
   logic [3:0]        busy;
   logic              err;

   modport master (
      output addr, data_in, rd, wr,
      input  data_out, stall, busy, err
   );

   modport slave (
      input  addr, data_in, rd, wr,
      output data_out, stall, busy, err
   );
endinterface

// File: rtl/banked_mem_responder.sv
// -----------------------------------------------------------------------------
// banked_mem_responder
// Four-bank interleaved word memory. One request accepted per cycle; a request
// to an occupied bank is stalled, illegal requests raise err and are dropped.
// Read data appears READ_LAT cycles after acceptance for one cycle.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (counters and read pipeline only;
//         storage keeps its contents)
//   bus : banked_mem_responder_if.slave (addr, data_in, rd, wr -> data_out,
//         stall, busy, err)
// -----------------------------------------------------------------------------

// Per-bank occupancy counter: loads BANK_LAT-1 on accept, counts down to 0.
module bmr_bank_occ #(
   parameter int BANK_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic busy
);
   logic [2:0] cnt_q, cnt_d;

   // load only ever arrives while cnt_q == 0 (accept requires !busy),
   // so the counter cannot wrap
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = 3'(BANK_LAT - 1);
      else if (cnt_q != 3'd0)
         cnt_d = cnt_q - 3'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != 3'd0);
endmodule

module banked_mem_responder #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int ROWS_W   = 8,
   parameter int BANK_LAT = 4,
   parameter int READ_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   banked_mem_responder_if.slave  bus
);
   localparam int ROWS   = 1 << ROWS_W;
   localparam int STAGES = READ_LAT - 1;

   logic [1:0]        bank;
   logic [ROWS_W-1:0] row;
   logic              req, err, stall, acc, rd_acc, wr_acc;
   logic [3:0]        busy;

   // upper address bits alias onto the same rows
   logic unused_addr;
   assign unused_addr = ^bus.addr[ADDR_W-1:ROWS_W+3];

   assign bank   = bus.addr[2:1];
   assign row    = bus.addr[ROWS_W+2:3];
   assign req    = bus.rd | bus.wr;
   assign err    = (bus.rd & bus.wr) | (req & bus.addr[0]);
   assign stall  = req & ~err & busy[bank];
   assign acc    = req & ~err & ~busy[bank];
   assign rd_acc = acc & bus.rd;
   assign wr_acc = acc & bus.wr;

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_bank
         bmr_bank_occ #(.BANK_LAT(BANK_LAT)) u_occ (
            .clk  (clk),
            .rst  (rst),
            .load (acc && (bank == 2'(b))),
            .busy (busy[b])
         );
      end
   endgenerate

   // storage: no reset, survives rst
   logic [DATA_W-1:0] mem_q [4][ROWS];

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[bank][row] <= bus.data_in;
   end

   // read return pipeline; stage 0 is loaded at the accept edge so the head
   // (stage STAGES) is visible READ_LAT cycles after acceptance
   logic [STAGES:0]             vld_pipe_q, vld_pipe_d;
   logic [STAGES:0][DATA_W-1:0] dat_pipe_q, dat_pipe_d;

   always_comb begin
      vld_pipe_d    = '0;
      dat_pipe_d    = '0;
      vld_pipe_d[0] = rd_acc;
      dat_pipe_d[0] = rd_acc ? mem_q[bank][row] : '0;
      for (int i = 1; i <= STAGES; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         dat_pipe_d[i] = dat_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
      end
   end

   assign bus.data_out = vld_pipe_q[STAGES] ? dat_pipe_q[STAGES] : '0;
   assign bus.stall    = stall;
   assign bus.err      = err;
   assign bus.busy     = busy;
endmodule

// File: tb/tb_banked_mem_responder.sv
module tb_banked_mem_responder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   banked_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   banked_mem_responder #(
      .ADDR_W(16), .DATA_W(16), .ROWS_W(8), .BANK_LAT(4), .READ_LAT(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          c;
      logic [15:0] d;
   } exp_t;
   exp_t sb[$];

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_hs(string nm, logic e_stall, logic e_err, logic [3:0] e_busy);
      chk({nm, "_stall"}, 16'(bus.stall), 16'(e_stall));
      chk({nm, "_err"},   16'(bus.err),   16'(e_err));
      chk({nm, "_busy"},  16'(bus.busy),  16'(e_busy));
   endtask

   // drive a request for one cycle; returns at the following negedge
   task automatic drive(logic [15:0] a, logic [15:0] d, logic r, logic w);
      @(posedge clk);
      #1;
      bus.addr    = a;
      bus.data_in = d;
      bus.rd      = r;
      bus.wr      = w;
      #4;
   endtask

   task automatic idle(int n);
      repeat (n) drive(16'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   // read accepted this cycle: data expected READ_LAT = 2 cycles later
   task automatic expect_rd(logic [15:0] d);
      exp_t e;
      e.c = cyc + 2;
      e.d = d;
      sb.push_back(e);
   endtask

   // monitor: data_out must match the scoreboard head in its cycle, else be 0
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].c < cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rdata_missed cyc=%0d exp_cyc=%0d exp=%h", cyc, sb[0].c, sb[0].d);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
         chk("rdata", bus.data_out, sb[0].d);
         void'(sb.pop_front());
      end else begin
         chk("dout_idle", bus.data_out, 16'h0000);
      end
   end

   initial begin
      bus.addr = '0; bus.data_in = '0; bus.rd = 1'b0; bus.wr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 16'(bus.busy), 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // write then read back, bank 2
      drive(16'h0004, 16'hBEEF, 1'b0, 1'b1); chk_hs("t1_wr", 1'b0, 1'b0, 4'b0000);
      repeat (3) begin
         idle(1); chk("t1_busy", 16'(bus.busy), 16'h0004);
      end
      drive(16'h0004, 16'h0000, 1'b1, 1'b0); chk_hs("t1_rd", 1'b0, 1'b0, 4'b0000);
      expect_rd(16'hBEEF);
      idle(4);

      // back-to-back preload writes across banks; bank 0 free again at t+4
      drive(16'h0000, 16'h0001, 1'b0, 1'b1); chk_hs("pl0", 1'b0, 1'b0, 4'b0000);
      drive(16'h0002, 16'h0002, 1'b0, 1'b1); chk_hs("pl1", 1'b0, 1'b0, 4'b0001);
      drive(16'h0004, 16'h0003, 1'b0, 1'b1); chk_hs("pl2", 1'b0, 1'b0, 4'b0011);
      drive(16'h0006, 16'h0004, 1'b0, 1'b1); chk_hs("pl3", 1'b0, 1'b0, 4'b0111);
      drive(16'h0008, 16'h5A5A, 1'b0, 1'b1); chk_hs("pl4", 1'b0, 1'b0, 4'b1110);
      idle(4);
      drive(16'h0010, 16'h1010, 1'b0, 1'b1); chk_hs("pl5", 1'b0, 1'b0, 4'b0000);
      idle(4);

      // interleaved reads, data 1..4 on consecutive cycles
      drive(16'h0000, 16'h0000, 1'b1, 1'b0); chk_hs("il0", 1'b0, 1'b0, 4'b0000); expect_rd(16'h0001);
      drive(16'h0002, 16'h0000, 1'b1, 1'b0); chk_hs("il1", 1'b0, 1'b0, 4'b0001); expect_rd(16'h0002);
      drive(16'h0004, 16'h0000, 1'b1, 1'b0); chk_hs("il2", 1'b0, 1'b0, 4'b0011); expect_rd(16'h0003);
      drive(16'h0006, 16'h0000, 1'b1, 1'b0); chk_hs("il3", 1'b0, 1'b0, 4'b0111); expect_rd(16'h0004);
      idle(4);

      // bank conflict: held request accepted in the first free cycle
      drive(16'h0000, 16'h0000, 1'b1, 1'b0); chk_hs("bc0", 1'b0, 1'b0, 4'b0000); expect_rd(16'h0001);
      repeat (3) begin
         drive(16'h0008, 16'h0000, 1'b1, 1'b0); chk_hs("bc_stall", 1'b1, 1'b0, 4'b0001);
      end
      drive(16'h0008, 16'h0000, 1'b1, 1'b0); chk_hs("bc_acc", 1'b0, 1'b0, 4'b0000); expect_rd(16'h5A5A);
      idle(4);

      // illegal requests change no state
      drive(16'h0002, 16'h0000, 1'b1, 1'b0); chk_hs("er0", 1'b0, 1'b0, 4'b0000); expect_rd(16'h0002);
      drive(16'h0010, 16'h7777, 1'b1, 1'b1); chk_hs("er_rdwr", 1'b0, 1'b1, 4'b0010);
      drive(16'h0011, 16'h0000, 1'b1, 1'b0); chk_hs("er_odd_rd", 1'b0, 1'b1, 4'b0010);
      drive(16'h0013, 16'hFFFF, 1'b0, 1'b1); chk_hs("er_odd_wr", 1'b0, 1'b1, 4'b0010);
      idle(1); chk_hs("er_idle", 1'b0, 1'b0, 4'b0000);
      idle(3);
      drive(16'h0010, 16'h0000, 1'b1, 1'b0); chk_hs("er_rb", 1'b0, 1'b0, 4'b0000); expect_rd(16'h1010);
      idle(4);

      // reset mid-read: pending data dropped, storage kept
      drive(16'h0006, 16'h0000, 1'b1, 1'b0); chk_hs("rs0", 1'b0, 1'b0, 4'b0000);
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      rst    = 1'b1;
      #4;
      chk("rs_busy_in", 16'(bus.busy), 16'h0000);
      #2;
      rst = 1'b0;
      drive(16'h0006, 16'h0000, 1'b1, 1'b0); chk_hs("rs_rd", 1'b0, 1'b0, 4'b0000); expect_rd(16'h0004);
      idle(1); chk("rs_busy3", 16'(bus.busy), 16'h0008);
      idle(4);

      // row 255 of bank 3 and upper-bit aliasing (0x0806 -> bank 3 row 0)
      drive(16'h07FE, 16'h1234, 1'b0, 1'b1); chk_hs("al_wr", 1'b0, 1'b0, 4'b0000);
      idle(4);
      drive(16'h0806, 16'hDEAD, 1'b0, 1'b1); chk_hs("al_wr2", 1'b0, 1'b0, 4'b0000);
      idle(4);
      drive(16'h07FE, 16'h0000, 1'b1, 1'b0); chk_hs("al_rd", 1'b0, 1'b0, 4'b0000); expect_rd(16'h1234);
      idle(4);
      drive(16'h0006, 16'h0000, 1'b1, 1'b0); chk_hs("al_rd2", 1'b0, 1'b0, 4'b0000); expect_rd(16'hDEAD);
      idle(4);

      chk("sb_drain", 16'(sb.size()), 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
